// File: rtl/hilo_register_file_pkg.sv
// Shared constants for the HI/LO register file: enable and reset encodings plus the default data width.
package hilo_register_file_pkg;

   localparam int   DEFAULT_DATA_WIDTH = 32;
   localparam logic WRITE_ENABLE       = 1'b1;
   localparam logic WRITE_DISABLE      = 1'b0;
   localparam logic RESET_ENABLE       = 1'b0;

endpackage

// File: rtl/hilo_bypass_mux.sv
// Forwarding mux for one architectural register.
// The youngest in-flight write (MEM) wins over WB, and WB wins over the committed value.
module hilo_bypass_mux
   import hilo_register_file_pkg::*;
#(
   parameter int WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic             memWriteEnable_i,
   input  logic [WIDTH-1:0] memWriteData_i,
   input  logic             wbWriteEnable_i,
   input  logic [WIDTH-1:0] wbWriteData_i,
   input  logic [WIDTH-1:0] committedData_i,
   output logic [WIDTH-1:0] readData_o
);

   assign readData_o = (memWriteEnable_i == WRITE_ENABLE) ? memWriteData_i :
                       (wbWriteEnable_i  == WRITE_ENABLE) ? wbWriteData_i  :
                                                            committedData_i;

endmodule

// File: rtl/hilo_register_file.sv
// Architectural HI/LO pair: commits WB-stage writes on the clock edge and serves EX reads
// with MEM/WB bypass so HI/LO hazards never need a stall.
module hilo_register_file
   import hilo_register_file_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  mem_register_hi_write_enable,
   input  logic [DATA_WIDTH-1:0] mem_register_hi_write_data,
   input  logic                  mem_register_lo_write_enable,
   input  logic [DATA_WIDTH-1:0] mem_register_lo_write_data,
   input  logic                  wb_register_hi_write_enable,
   input  logic [DATA_WIDTH-1:0] wb_register_hi_write_data,
   input  logic                  wb_register_lo_write_enable,
   input  logic [DATA_WIDTH-1:0] wb_register_lo_write_data,
   output logic [DATA_WIDTH-1:0] hi_read_data,
   output logic [DATA_WIDTH-1:0] lo_read_data,
   output logic [DATA_WIDTH-1:0] hi_value,
   output logic [DATA_WIDTH-1:0] lo_value
);

   logic [DATA_WIDTH-1:0] hiQ, hiD;
   logic [DATA_WIDTH-1:0] loQ, loD;

   // HI and LO commit independently so MTHI/MTLO leave the other half alone.
   assign hiD = (wb_register_hi_write_enable == WRITE_ENABLE) ? wb_register_hi_write_data : hiQ;
   assign loD = (wb_register_lo_write_enable == WRITE_ENABLE) ? wb_register_lo_write_data : loQ;

   always_ff @(posedge clock or negedge reset) begin
      if (reset == RESET_ENABLE) begin
         hiQ <= '0;
         loQ <= '0;
      end else begin
         hiQ <= hiD;
         loQ <= loD;
      end
   end

   assign hi_value = hiQ;
   assign lo_value = loQ;

   hilo_bypass_mux #(.WIDTH(DATA_WIDTH)) hiBypass (
      .memWriteEnable_i (mem_register_hi_write_enable),
      .memWriteData_i   (mem_register_hi_write_data),
      .wbWriteEnable_i  (wb_register_hi_write_enable),
      .wbWriteData_i    (wb_register_hi_write_data),
      .committedData_i  (hiQ),
      .readData_o       (hi_read_data)
   );

   hilo_bypass_mux #(.WIDTH(DATA_WIDTH)) loBypass (
      .memWriteEnable_i (mem_register_lo_write_enable),
      .memWriteData_i   (mem_register_lo_write_data),
      .wbWriteEnable_i  (wb_register_lo_write_enable),
      .wbWriteData_i    (wb_register_lo_write_data),
      .committedData_i  (loQ),
      .readData_o       (lo_read_data)
   );

endmodule

// File: tb/tb_hilo_register_file.sv
// Self-checking bench for hilo_register_file: directed scenarios plus randomized traffic
// compared against a simple HI/LO architectural model.
module tb_hilo_register_file;

   logic        clock = 1'b0;
   logic        reset;
   logic        memHiEn, memLoEn, wbHiEn, wbLoEn;
   logic [31:0] memHiData, memLoData, wbHiData, wbLoData;
   logic [31:0] hiReadData, loReadData, hiValue, loValue;

   int          checkCount = 0;
   int          passCount  = 0;
   logic [31:0] refHi, refLo;

   always #5 clock = ~clock;

   hilo_register_file #(.DATA_WIDTH(32)) dut (
      .clock                        (clock),
      .reset                        (reset),
      .mem_register_hi_write_enable (memHiEn),
      .mem_register_hi_write_data   (memHiData),
      .mem_register_lo_write_enable (memLoEn),
      .mem_register_lo_write_data   (memLoData),
      .wb_register_hi_write_enable  (wbHiEn),
      .wb_register_hi_write_data    (wbHiData),
      .wb_register_lo_write_enable  (wbLoEn),
      .wb_register_lo_write_data    (wbLoData),
      .hi_read_data                 (hiReadData),
      .lo_read_data                 (loReadData),
      .hi_value                     (hiValue),
      .lo_value                     (loValue)
   );

   function automatic logic [31:0] expHiRead();
      if (memHiEn) return memHiData;
      if (wbHiEn)  return wbHiData;
      return refHi;
   endfunction

   function automatic logic [31:0] expLoRead();
      if (memLoEn) return memLoData;
      if (wbLoEn)  return wbLoData;
      return refLo;
   endfunction

   task automatic clearInputs();
      memHiEn = 1'b0; memLoEn = 1'b0; wbHiEn = 1'b0; wbLoEn = 1'b0;
      memHiData = '0; memLoData = '0; wbHiData = '0; wbLoData = '0;
   endtask

   // Model commits what WB presents (if out of reset), then waits just past the edge.
   task automatic tick();
      if (reset) begin
         if (wbHiEn) refHi = wbHiData;
         if (wbLoEn) refLo = wbLoData;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; refHi = '0; refLo = '0;
      clearInputs();
      #12;
      checkCount++; if (hiValue !== 32'h0) $display("[TB] FAIL reset_hi_value actual=%h expected=%h", hiValue, 32'h0); else passCount++;
      checkCount++; if (loValue !== 32'h0) $display("[TB] FAIL reset_lo_value actual=%h expected=%h", loValue, 32'h0); else passCount++;
      checkCount++; if (hiReadData !== 32'h0) $display("[TB] FAIL reset_hi_read actual=%h expected=%h", hiReadData, 32'h0); else passCount++;
      @(posedge clock); #1;
      reset = 1'b1;
      wbHiEn = 1'b1; wbHiData = 32'h1234;
      wbLoEn = 1'b1; wbLoData = 32'h5678;
      tick();
      clearInputs();
      checkCount++; if (hiValue !== refHi) $display("[TB] FAIL pre_reset_hi actual=%h expected=%h", hiValue, refHi); else passCount++;
      #2;
      reset = 1'b0; refHi = '0; refLo = '0;
      #1;
      checkCount++; if (hiValue !== 32'h0) $display("[TB] FAIL async_reset_hi actual=%h expected=%h", hiValue, 32'h0); else passCount++;
      checkCount++; if (loValue !== 32'h0) $display("[TB] FAIL async_reset_lo actual=%h expected=%h", loValue, 32'h0); else passCount++;
      reset = 1'b1;
      tick();
   endtask

   task automatic test_commit();
      wbHiEn = 1'b1; wbHiData = 32'hDEADBEEF;
      wbLoEn = 1'b1; wbLoData = 32'h00000007;
      tick();
      clearInputs();
      checkCount++; if (hiValue !== 32'hDEADBEEF) $display("[TB] FAIL commit_hi actual=%h expected=%h", hiValue, 32'hDEADBEEF); else passCount++;
      checkCount++; if (loValue !== 32'h7) $display("[TB] FAIL commit_lo actual=%h expected=%h", loValue, 32'h7); else passCount++;
      wbHiData = 32'h0BAD0BAD; wbLoData = 32'h0BAD0BAD;
      tick();
      checkCount++; if (hiValue !== refHi) $display("[TB] FAIL hold_hi actual=%h expected=%h", hiValue, refHi); else passCount++;
      checkCount++; if (loValue !== refLo) $display("[TB] FAIL hold_lo actual=%h expected=%h", loValue, refLo); else passCount++;
      clearInputs();
   endtask

   task automatic test_bypass_priority();
      wbHiEn = 1'b1; wbHiData = 32'h11;
      tick();
      clearInputs();
      wbHiEn = 1'b1; wbHiData = 32'h22;
      memHiEn = 1'b1; memHiData = 32'h33;
      #1;
      checkCount++; if (hiReadData !== 32'h33) $display("[TB] FAIL bypass_mem actual=%h expected=%h", hiReadData, 32'h33); else passCount++;
      checkCount++; if (hiValue !== 32'h11) $display("[TB] FAIL bypass_committed actual=%h expected=%h", hiValue, 32'h11); else passCount++;
      memHiEn = 1'b0;
      #1;
      checkCount++; if (hiReadData !== 32'h22) $display("[TB] FAIL bypass_wb actual=%h expected=%h", hiReadData, 32'h22); else passCount++;
      tick();
      clearInputs();
      #1;
      checkCount++; if (hiReadData !== 32'h22) $display("[TB] FAIL bypass_after_commit actual=%h expected=%h", hiReadData, 32'h22); else passCount++;
   endtask

   task automatic test_independence();
      wbLoEn = 1'b1; wbLoData = 32'h5;
      tick();
      clearInputs();
      wbHiEn = 1'b1; wbHiData = 32'hAAAA5555;
      wbLoData = 32'hFFFF0000;
      #1;
      checkCount++; if (loReadData !== 32'h5) $display("[TB] FAIL indep_lo_read_live actual=%h expected=%h", loReadData, 32'h5); else passCount++;
      tick();
      clearInputs();
      checkCount++; if (loValue !== 32'h5) $display("[TB] FAIL indep_lo_value actual=%h expected=%h", loValue, 32'h5); else passCount++;
      checkCount++; if (hiValue !== 32'hAAAA5555) $display("[TB] FAIL indep_hi_value actual=%h expected=%h", hiValue, 32'hAAAA5555); else passCount++;
   endtask

   task automatic test_back_to_back();
      memHiEn = 1'b1; memHiData = 32'hFFFFFFFE;
      memLoEn = 1'b1; memLoData = 32'h00000002;
      #1;
      checkCount++; if (hiReadData !== 32'hFFFFFFFE) $display("[TB] FAIL b2b_mem_stage actual=%h expected=%h", hiReadData, 32'hFFFFFFFE); else passCount++;
      tick();
      clearInputs();
      wbHiEn = 1'b1; wbHiData = 32'hFFFFFFFE;
      wbLoEn = 1'b1; wbLoData = 32'h00000002;
      #1;
      checkCount++; if (hiReadData !== 32'hFFFFFFFE) $display("[TB] FAIL b2b_wb_stage actual=%h expected=%h", hiReadData, 32'hFFFFFFFE); else passCount++;
      checkCount++; if (loReadData !== 32'h2) $display("[TB] FAIL b2b_wb_stage_lo actual=%h expected=%h", loReadData, 32'h2); else passCount++;
      tick();
      clearInputs();
      #1;
      checkCount++; if (hiReadData !== 32'hFFFFFFFE) $display("[TB] FAIL b2b_committed_read actual=%h expected=%h", hiReadData, 32'hFFFFFFFE); else passCount++;
      checkCount++; if (hiValue !== 32'hFFFFFFFE) $display("[TB] FAIL b2b_hi_value actual=%h expected=%h", hiValue, 32'hFFFFFFFE); else passCount++;
   endtask

   task automatic test_reset_during_write();
      wbHiEn = 1'b1; wbHiData = 32'h99;
      #1;
      reset = 1'b0; refHi = '0; refLo = '0;
      tick();
      checkCount++; if (hiValue !== 32'h0) $display("[TB] FAIL reset_wb_discard actual=%h expected=%h", hiValue, 32'h0); else passCount++;
      checkCount++; if (hiReadData !== 32'h99) $display("[TB] FAIL reset_live_bypass actual=%h expected=%h", hiReadData, 32'h99); else passCount++;
      clearInputs();
      reset = 1'b1;
      tick();
      checkCount++; if (hiValue !== 32'h0) $display("[TB] FAIL reset_release_hi actual=%h expected=%h", hiValue, 32'h0); else passCount++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         memHiEn = 1'($urandom_range(0, 1)); memHiData = $urandom;
         memLoEn = 1'($urandom_range(0, 1)); memLoData = $urandom;
         wbHiEn  = 1'($urandom_range(0, 1)); wbHiData  = $urandom;
         wbLoEn  = 1'($urandom_range(0, 1)); wbLoData  = $urandom;
         if ($urandom_range(0, 24) == 0) begin
            reset = 1'b0; refHi = '0; refLo = '0;
         end else begin
            reset = 1'b1;
         end
         #1;
         checkCount++; if (hiReadData !== expHiRead()) $display("[TB] FAIL rand_hi_read i=%0d actual=%h expected=%h", i, hiReadData, expHiRead()); else passCount++;
         checkCount++; if (loReadData !== expLoRead()) $display("[TB] FAIL rand_lo_read i=%0d actual=%h expected=%h", i, loReadData, expLoRead()); else passCount++;
         tick();
         checkCount++; if (hiValue !== refHi) $display("[TB] FAIL rand_hi_value i=%0d actual=%h expected=%h", i, hiValue, refHi); else passCount++;
         checkCount++; if (loValue !== refLo) $display("[TB] FAIL rand_lo_value i=%0d actual=%h expected=%h", i, loValue, refLo); else passCount++;
      end
      clearInputs();
      reset = 1'b1;
   endtask

   initial begin
      test_reset();
      test_commit();
      test_bypass_priority();
      test_independence();
      test_back_to_back();
      test_reset_during_write();
      test_random();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
